// File: rtl/rf_pkg.sv
// Shared types and helpers for the register file with busy scoreboard.
// The ZERO_REG rule lives here so every user applies it identically.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

  // Register 0 is hardwired when the zero-register option is enabled.
  function automatic logic is_writable(input int unsigned addr, input bit zero_reg);
    return !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: array mux, optional same-cycle write bypass,
// and the hardwired-zero register override.
module rf_read_port
  import rf_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NREGS    = NREGS_DEF,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic [XLEN-1:0] regs_i [NREGS],
  input  logic [AW-1:0]   addr_i,
  input  logic            we_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  output logic [XLEN-1:0] data_o
);

  logic zero_sel;
  logic hit;

  always_comb begin
    zero_sel = (ZERO_REG != 0) && (addr_i == '0);
    hit      = (BYPASS != 0) && we_i && (wr_addr_i == addr_i)
               && is_writable(32'(addr_i), ZERO_REG != 0);
    data_o   = regs_i[addr_i];
    if (hit) begin
      data_o = wr_data_i;
    end
    // Zero override has the final word, even over a bypassed write.
    if (zero_sel) begin
      data_o = '0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with per-register busy scoreboard and occupancy
// counter; issue reserves a destination, writeback releases it.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NREGS    = NREGS_DEF,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [AW:0]     busy_count
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic             wr_ok;
  logic             issue_set;
  logic             cnt_inc;
  logic             cnt_dec;
  logic             rs1_hit;
  logic             rs2_hit;

  function automatic logic wr_able(input logic [AW-1:0] a);
    return is_writable(32'(a), ZERO_REG != 0);
  endfunction

  always_comb begin
    wr_ok       = we && wr_able(wr_addr);
    // A writeback releasing the same register this cycle frees it for a new producer.
    issue_ready = !busy_q[issue_rd] || (we && (wr_addr == issue_rd)) || !wr_able(issue_rd);
    issue_set   = issue_valid && issue_ready && wr_able(issue_rd);

    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (issue_set) begin
      busy_d[issue_rd] = 1'b1;
    end

    // Count only real transitions so the counter tracks popcount(busy).
    cnt_inc = issue_set && !busy_q[issue_rd];
    cnt_dec = wr_ok && busy_q[wr_addr] && !(issue_set && (issue_rd == wr_addr));
    cnt_d   = cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};

    rs1_hit  = (BYPASS != 0) && wr_ok && (wr_addr == rs1_addr);
    rs2_hit  = (BYPASS != 0) && wr_ok && (wr_addr == rs2_addr);
    rs1_busy = busy_q[rs1_addr] && !rs1_hit && wr_able(rs1_addr);
    rs2_busy = busy_q[rs2_addr] && !rs2_hit && wr_able(rs2_addr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) begin
        regs_q[wr_addr] <= wr_data;
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_count = cnt_q;

  rf_read_port #(
    .XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rs1 (
    .regs_i(regs_q), .addr_i(rs1_addr), .we_i(we),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .data_o(rs1_data)
  );

  rf_read_port #(
    .XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rs2 (
    .regs_i(regs_q), .addr_i(rs2_addr), .we_i(we),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .data_o(rs2_data)
  );

  // Debug port shows the raw array contents, never forwarded data.
  rf_read_port #(
    .XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(ZERO_REG), .BYPASS(0)
  ) u_dbg (
    .regs_i(regs_q), .addr_i(dbg_addr), .we_i(we),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .data_o(dbg_data)
  );

endmodule
